// File: rtl/nvm_gc_ctrl.sv
// nvm_gc_ctrl - garbage-collection sequencer for the NVM flash controller.
//
// Picks up a victim block when free space runs low (or on gc_force). It then
// relocates every valid page through READ/PROG flash commands to
// allocator-supplied destinations, pulses a map update per page, and finally
// erases the victim. Host traffic may pause the scan between page moves.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   free_blocks, gc_force          run triggers (sampled in IDLE only)
//   host_req                       host pending; GC yields at a page boundary
//   victim_req/vld/blk, page_map   victim handshake with the block manager
//   alloc_req/ack, dest_blk/page   destination handshake with the allocator
//   fcmd_vld/rdy, fcmd, fblk,      flash command port (valid/ready) and
//   fpage, fdone                   completion strobe
//   map_upd, map_old_page          one-cycle remap request per moved page
//   gc_yield, gc_busy, gc_done     status
//   gc_state, pages_moved          debug/status of the current run

module nvm_gc_ctrl #(
  parameter int BLOCK_W      = 10,
  parameter int PAGE_W       = 6,
  parameter int GC_THRESHOLD = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [BLOCK_W:0]   free_blocks,
  input  logic               gc_force,
  input  logic               host_req,
  output logic               victim_req,
  input  logic               victim_vld,
  input  logic [BLOCK_W-1:0] victim_blk,
  input  logic [2**PAGE_W-1:0] page_map,
  output logic               alloc_req,
  input  logic               alloc_ack,
  input  logic [BLOCK_W-1:0] dest_blk,
  input  logic [PAGE_W-1:0]  dest_page,
  output logic               fcmd_vld,
  input  logic               fcmd_rdy,
  output logic [1:0]         fcmd,
  output logic [BLOCK_W-1:0] fblk,
  output logic [PAGE_W-1:0]  fpage,
  input  logic               fdone,
  output logic               map_upd,
  output logic [PAGE_W-1:0]  map_old_page,
  output logic               gc_yield,
  output logic               gc_busy,
  output logic               gc_done,
  output logic [3:0]         gc_state,
  output logic [PAGE_W:0]    pages_moved
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INTERRUPT  = 4'd1,
    ST_INI        = 4'd2,
    ST_INI_DONE   = 4'd3,
    ST_MOVE_START = 4'd4,
    ST_FINISH     = 4'd5
  } state_t;

  // ER_CMD/ER_WAIT are the two halves of FINISH; the rest belong to a page move.
  typedef enum logic [2:0] {
    PH_ALLOC,
    PH_RD_CMD,
    PH_RD_WAIT,
    PH_PG_CMD,
    PH_PG_WAIT,
    PH_MAP,
    PH_ER_CMD,
    PH_ER_WAIT
  } phase_t;

  localparam logic [1:0]         CMD_NOP   = 2'd0;
  localparam logic [1:0]         CMD_READ  = 2'd1;
  localparam logic [1:0]         CMD_PROG  = 2'd2;
  localparam logic [1:0]         CMD_ERASE = 2'd3;
  localparam logic [PAGE_W-1:0]  LAST_PAGE = '1;
  localparam logic [BLOCK_W:0]   THRESH    = (BLOCK_W+1)'(GC_THRESHOLD);

  state_t                state;
  phase_t                phase;
  logic [PAGE_W-1:0]     page_idx;
  logic [BLOCK_W-1:0]    victim_q;
  logic [2**PAGE_W-1:0]  map_q;
  logic [BLOCK_W-1:0]    dest_blk_q;
  logic [PAGE_W-1:0]     dest_page_q;

  // Status and request levels decode straight from the state/phase flops.
  assign gc_state   = state;
  assign gc_busy    = (state != ST_IDLE);
  assign gc_yield   = (state == ST_INTERRUPT);
  assign victim_req = (state == ST_INI);
  assign alloc_req  = (state == ST_MOVE_START) && (phase == PH_ALLOC);

  // Sequencer: the state, the move sub-phase and every registered output.
  // Commands are loaded into fcmd_vld/fcmd/fblk/fpage on entry to a *_CMD
  // phase and stay frozen until the accepting cycle, which drops the valid
  // and moves to the matching wait phase. fdone is only looked at in waits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      phase        <= PH_ALLOC;
      page_idx     <= '0;
      victim_q     <= '0;
      map_q        <= '0;
      dest_blk_q   <= '0;
      dest_page_q  <= '0;
      fcmd_vld     <= 1'b0;
      fcmd         <= CMD_NOP;
      fblk         <= '0;
      fpage        <= '0;
      map_upd      <= 1'b0;
      map_old_page <= '0;
      gc_done      <= 1'b0;
      pages_moved  <= '0;
    end else begin
      map_upd <= 1'b0;
      gc_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((free_blocks < THRESH) || gc_force)
            state <= ST_INI;
        end
        ST_INI: begin
          if (victim_vld) begin
            victim_q    <= victim_blk;
            map_q       <= page_map;
            page_idx    <= '0;
            pages_moved <= '0;
            state       <= ST_INI_DONE;
          end
        end
        ST_INI_DONE: begin
          if (!map_q[page_idx]) begin
            if (page_idx == LAST_PAGE) begin
              state    <= ST_FINISH;
              phase    <= PH_ER_CMD;
              fcmd_vld <= 1'b1;
              fcmd     <= CMD_ERASE;
              fblk     <= victim_q;
              fpage    <= '0;
            end else begin
              page_idx <= page_idx + 1'b1;
            end
          end else if (host_req) begin
            state <= ST_INTERRUPT;
          end else begin
            state <= ST_MOVE_START;
            phase <= PH_ALLOC;
          end
        end
        ST_INTERRUPT: begin
          if (!host_req)
            state <= ST_INI_DONE;
        end
        ST_MOVE_START: begin
          case (phase)
            PH_ALLOC: begin
              if (alloc_ack) begin
                dest_blk_q  <= dest_blk;
                dest_page_q <= dest_page;
                phase       <= PH_RD_CMD;
                fcmd_vld    <= 1'b1;
                fcmd        <= CMD_READ;
                fblk        <= victim_q;
                fpage       <= page_idx;
              end
            end
            PH_RD_CMD: begin
              if (fcmd_rdy) begin
                fcmd_vld <= 1'b0;
                fcmd     <= CMD_NOP;
                phase    <= PH_RD_WAIT;
              end
            end
            PH_RD_WAIT: begin
              if (fdone) begin
                phase    <= PH_PG_CMD;
                fcmd_vld <= 1'b1;
                fcmd     <= CMD_PROG;
                fblk     <= dest_blk_q;
                fpage    <= dest_page_q;
              end
            end
            PH_PG_CMD: begin
              if (fcmd_rdy) begin
                fcmd_vld <= 1'b0;
                fcmd     <= CMD_NOP;
                phase    <= PH_PG_WAIT;
              end
            end
            PH_PG_WAIT: begin
              if (fdone) begin
                phase        <= PH_MAP;
                map_upd      <= 1'b1;
                map_old_page <= page_idx;
                pages_moved  <= pages_moved + 1'b1;
              end
            end
            PH_MAP: begin
              if (page_idx == LAST_PAGE) begin
                state    <= ST_FINISH;
                phase    <= PH_ER_CMD;
                fcmd_vld <= 1'b1;
                fcmd     <= CMD_ERASE;
                fblk     <= victim_q;
                fpage    <= '0;
              end else begin
                page_idx <= page_idx + 1'b1;
                state    <= ST_INI_DONE;
              end
            end
            default: phase <= PH_ALLOC;
          endcase
        end
        ST_FINISH: begin
          if (phase == PH_ER_CMD) begin
            if (fcmd_rdy) begin
              fcmd_vld <= 1'b0;
              fcmd     <= CMD_NOP;
              phase    <= PH_ER_WAIT;
            end
          end else if (fdone) begin
            gc_done <= 1'b1;
            state   <= ST_IDLE;
            phase   <= PH_ALLOC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
